// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, issues sequential 1-cycle imem reads and
// buffers {instr, pc} in a DEPTH-entry FIFO that feeds decode.
module fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PCsrc_E,
    input  logic [WIDTH-1:0]         PCTarget_E,
    input  logic                     stall_D,
    output logic                     imem_req,
    output logic [WIDTH-1:0]         imem_addr,
    input  logic [WIDTH-1:0]         imem_rdata,
    output logic [WIDTH-1:0]         instr_F,
    output logic [WIDTH-1:0]         PC_F,
    output logic [WIDTH-1:0]         PCPlus4_F,
    output logic                     valid_F,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] NOP = WIDTH'(32'h0000_0013);

    logic [WIDTH-1:0]             fetch_pc;
    logic [WIDTH-1:0]             req_pc;
    logic [WIDTH-1:0]             last_pc;
    logic                         inflight;
    logic [PW-1:0]                rd_ptr;
    logic [PW-1:0]                wr_ptr;
    logic [DEPTH-1:0][WIDTH-1:0]  buf_instr;
    logic [DEPTH-1:0][WIDTH-1:0]  buf_pc;
    logic                         push;
    logic                         pop;

    // Reserve a slot for the in-flight word; a same-cycle pop is not credited.
    assign imem_req  = rst && !PCsrc_E && ((count + CW'(inflight)) < CW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign valid_F   = (count != '0);
    assign push      = inflight && !PCsrc_E;
    assign pop       = valid_F && !stall_D && !PCsrc_E;
    assign instr_F   = valid_F ? buf_instr[rd_ptr] : NOP;
    assign PC_F      = valid_F ? buf_pc[rd_ptr] : last_pc;
    assign PCPlus4_F = PC_F + WIDTH'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            last_pc   <= '0;
            inflight  <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            buf_instr <= '0;
            buf_pc    <= '0;
        end else if (PCsrc_E) begin
            // Redirect drops queued entries and any response landing this cycle.
            fetch_pc <= PCTarget_E;
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + WIDTH'(4);
                req_pc   <= fetch_pc;
            end
            if (push) begin
                buf_instr[wr_ptr] <= imem_rdata;
                buf_pc[wr_ptr]    <= req_pc;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (valid_F)
                last_pc <= buf_pc[rd_ptr];
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=4 instance plus a DEPTH=8 instance
// sharing stimulus, each with its own 1-cycle imem returning 0xA000_0000|addr.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCsrc_E = 1'b0;
    logic [31:0] PCTarget_E = '0;
    logic        stall_D = 1'b0;

    logic        req4, valid4, req8, valid8;
    logic [31:0] addr4, rdata4, instr4, pc4, pcp4_4;
    logic [31:0] addr8, rdata8, instr8, pc8, pcp4_8;
    logic [2:0]  count4;
    logic [3:0]  count8;

    int checks = 0;
    int failures = 0;
    int pops4, pops8;
    logic [31:0] exp4, exp8;

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut4 (
        .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E),
        .stall_D(stall_D), .imem_req(req4), .imem_addr(addr4), .imem_rdata(rdata4),
        .instr_F(instr4), .PC_F(pc4), .PCPlus4_F(pcp4_4), .valid_F(valid4), .count(count4)
    );

    fetch_queue #(.WIDTH(32), .DEPTH(8), .RESET_PC(32'h0)) u_dut8 (
        .clk(clk), .rst(rst), .PCsrc_E(PCsrc_E), .PCTarget_E(PCTarget_E),
        .stall_D(stall_D), .imem_req(req8), .imem_addr(addr8), .imem_rdata(rdata8),
        .instr_F(instr8), .PC_F(pc8), .PCPlus4_F(pcp4_8), .valid_F(valid8), .count(count8)
    );

    always #5 clk = ~clk;

    initial rdata4 = '0;
    initial rdata8 = '0;
    always @(posedge clk) if (req4) rdata4 <= 32'hA000_0000 | addr4;
    always @(posedge clk) if (req8) rdata8 <= 32'hA000_0000 | addr8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset state, then streaming from RESET_PC
        #1;
        chk("rst_valid", 32'(valid4), 0);
        chk("rst_req", 32'(req4), 0);
        chk("rst_instr", instr4, 32'h13);
        chk("rst_pc", pc4, 0);
        chk("rst_pcp4", pcp4_4, 4);
        chk("rst_count", 32'(count4), 0);
        chk("rst_count8", 32'(count8), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t1_req0", 32'(req4), 1);
        chk("t1_addr0", addr4, 0);
        cyc();
        chk("t1_addr1", addr4, 4);
        chk("t1_valid_e1", 32'(valid4), 0);
        cyc();
        chk("t1_valid_e2", 32'(valid4), 1);
        chk("t1_instr_e2", instr4, 32'hA000_0000);
        chk("t1_pc_e2", pc4, 0);
        chk("t1_pcp4_e2", pcp4_4, 4);
        chk("t1_addr2", addr4, 8);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("t1_stream_pc", pc4, 32'(4 * i));
            chk("t1_stream_instr", instr4, 32'hA000_0000 | 32'(4 * i));
        end

        // 2: stall from reset fills the queue, then drains without gaps
        cyc();
        rst = 1'b0;
        stall_D = 1'b1;
        #2;
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            cyc();
            chk("t2_count", 32'(count4), (e - 1 > 4) ? 4 : 32'(e - 1));
            if (e >= 4) chk("t2_req_off", 32'(req4), 0);
            if (e >= 2) chk("t2_pc_hold", pc4, 0);
        end
        stall_D = 1'b0;
        #1;
        for (int i = 0; i <= 4; i++) begin
            chk("t2_drain_pc", pc4, 32'(4 * i));
            chk("t2_drain_valid", 32'(valid4), 1);
            cyc();
        end

        // 4: redirect coincident with a pop condition wins
        PCsrc_E = 1'b1;
        PCTarget_E = 32'h40;
        #1;
        chk("t4_req_redir", 32'(req4), 0);
        chk("t4_pop_cond", 32'(valid4), 1);
        cyc();
        PCsrc_E = 1'b0;
        stall_D = 1'b1;
        #1;
        chk("t4_count", 32'(count4), 0);
        chk("t4_valid", 32'(valid4), 0);
        chk("t4_instr", instr4, 32'h13);
        chk("t4_req", 32'(req4), 1);
        chk("t4_addr", addr4, 32'h40);
        for (int e = 1; e <= 4; e++) begin
            cyc();
            if (e >= 2) chk("t4_head", pc4, 32'h40);
        end
        chk("t4_count3", 32'(count4), 3);
        chk("t4_req_full", 32'(req4), 0);

        // 3: redirect with count=3 and 0x4C in flight, also under stall
        PCsrc_E = 1'b1;
        PCTarget_E = 32'h100;
        #1;
        cyc();
        PCsrc_E = 1'b0;
        stall_D = 1'b0;
        #1;
        chk("t3_count", 32'(count4), 0);
        chk("t3_valid", 32'(valid4), 0);
        chk("t3_instr", instr4, 32'h13);
        chk("t3_req", 32'(req4), 1);
        chk("t3_addr", addr4, 32'h100);
        cyc();
        chk("t3_valid_e1", 32'(valid4), 0);
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("t3_pc", pc4, 32'h100 + 32'(4 * i));
            chk("t3_instr", instr4, 32'hA000_0100 + 32'(4 * i));
            cyc();
        end

        // 5: random stall across pointer wrap, both depths
        PCsrc_E = 1'b1;
        PCTarget_E = 32'h200;
        #1;
        cyc();
        PCsrc_E = 1'b0;
        exp4 = 32'h200;
        exp8 = 32'h200;
        pops4 = 0;
        pops8 = 0;
        for (int c = 0; c < 400 && (pops4 < 20 || pops8 < 20); c++) begin
            stall_D = ($urandom_range(0, 2) == 0);
            #1;
            if (valid4 && !stall_D && pops4 < 20) begin
                chk("t5_pc4", pc4, exp4);
                chk("t5_instr4", instr4, 32'hA000_0000 | exp4);
                exp4 += 4;
                pops4++;
            end
            if (valid8 && !stall_D && pops8 < 20) begin
                chk("t5_pc8", pc8, exp8);
                chk("t5_instr8", instr8, 32'hA000_0000 | exp8);
                exp8 += 4;
                pops8++;
            end
            cyc();
        end
        chk("t5_done4", 32'(pops4), 20);
        chk("t5_done8", 32'(pops8), 20);

        // 6: asynchronous reset mid-cycle with count=2
        PCsrc_E = 1'b1;
        PCTarget_E = 32'h300;
        stall_D = 1'b1;
        #1;
        cyc();
        PCsrc_E = 1'b0;
        cyc();
        cyc();
        cyc();
        chk("t6_count2", 32'(count4), 2);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(valid4), 0);
        chk("t6_count", 32'(count4), 0);
        chk("t6_req", 32'(req4), 0);
        cyc();
        #2;
        rst = 1'b1;
        stall_D = 1'b0;
        #1;
        chk("t6_addr", addr4, 0);
        chk("t6_req_on", 32'(req4), 1);
        cyc();
        cyc();
        chk("t6_valid_e2", 32'(valid4), 1);
        chk("t6_pc", pc4, 0);
        chk("t6_instr", instr4, 32'hA000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
